mmu_result_tx: RTL and testbench
================================

# mmu_result_tx

Transmit-side result path of the 4x4 systolic accelerator. Accepts 128-bit result rows from the MMU and buffers them in a small row FIFO. Serializes each row into four 32-bit AXI4-Stream beats on the master port toward the AXI DMA S2MM channel. Marks the final beat of each 4x4 result matrix with `m_axis_last` and pulses `o_intr` when the matrix has fully left the block.

## Interface
- `DATA_W`, 32, width of one result element and of the stream data bus
- `LANES`, 4, elements per MMU row (`i_row_data` width = `DATA_W*LANES`)
- `ROWS`, 4, rows per result matrix (beats per matrix = `LANES*ROWS`)
- `FIFO_DEPTH`, 4, row FIFO entries; must be a power of two and at least 2

- `axi_clk` in 1: single clock
- `axi_rst` in 1: reset, asynchronous, active-low
- `i_row_data` in 128: one MMU result row; lane k = bits [32k+31:32k]
- `i_row_valid` in 1: row present on `i_row_data`
- `i_row_ready` out 1: row FIFO can accept a row
- `m_axis_data` out 32: stream data
- `m_axis_valid` out 1: stream beat valid
- `m_axis_ready` in 1: downstream accepts the beat
- `m_axis_last` out 1: final beat of a matrix
- `o_intr` out 1: one-cycle pulse per matrix transmitted
- `o_busy` out 1: FIFO non-empty or beat pending

## Operation
- **Row write:** a row is written when `i_row_valid && i_row_ready`.
  - `i_row_ready` = !full, combinational from FIFO state.
  - A valid row offered while full is held off; it is never dropped.
- **Serializer FSM** has two states:
  - **IDLE:** on FIFO non-empty, pop one row into the shift register, set beat=0, and go to SEND.
  - **SEND:** `m_axis_valid`=1 and `m_axis_data` = lane[beat]. Lane 0 is sent first.
  - On handshake with beat<3: beat is incremented.
  - On handshake with beat==3 and FIFO non-empty: pop the next row and stay in SEND, with no bubble.
  - On handshake with beat==3 and FIFO empty: go to IDLE.
- **Row counter:** counts 0..ROWS-1 and increments on each completed row.
  - `m_axis_last` = (row==ROWS-1) && (beat==LANES-1) while valid.
  - The counter wraps to 0 after the last row.
- **Interrupt:** `o_intr` is asserted for exactly one cycle, in the cycle after the `m_axis_last` handshake.
- **Simultaneous events:** a FIFO pop and a FIFO push in the same cycle are both performed. Occupancy stays unchanged, and with a full FIFO `i_row_ready` stays 0 that cycle.
- **Reset mid-operation:** reset clears all state and discards any buffered rows and any partial matrix. The row counter restarts at 0.

## Timing
- **Reset values:**
  - `m_axis_valid`, `m_axis_last`, `o_intr`, `o_busy` = 0.
  - `m_axis_data` = 0.
  - `i_row_ready` = 1 once reset is released, because the FIFO is empty.
- **Latency:** a row written in cycle N appears as the first beat (`m_axis_valid`=1, lane 0) in cycle N+2 when the block is idle. This is one cycle for the FIFO write and one for the pop into the register.
- **Throughput:**
  - Sustained rate is 1 beat per cycle with `m_axis_ready` held high.
  - A full matrix takes 16 consecutive beats.
  - Rows drain at 1 per 4 cycles.
- **AXIS rules:**
  - While `m_axis_valid`=1 and `m_axis_ready`=0, `m_axis_data` and `m_axis_last` are held stable.
  - `m_axis_valid` is never deasserted without a handshake.
  - `m_axis_valid` does not depend combinationally on `m_axis_ready`.
- **Outputs:** all stream outputs and `o_intr` are registered.

## Structure
- **Shared package `systolic_pkg`:**
  - `DATA_W`, `LANES`, `ROWS`.
  - Typedefs for the row vector and the lane index.
  - FSM state enum {IDLE, SEND}.
- **Sub-module `result_row_fifo`:** synchronous row FIFO with full/empty flags and a simultaneous read/write path. The serializer FSM, beat/row counters and interrupt logic live in the top.

## Test plan
- **Single matrix, no backpressure:** push rows 0x{03,02,01,00}, ..., 0x{0F,0E,0D,0C} (lane0 lowest).
  - Expect 16 beats 0x00..0x0F on consecutive cycles.
  - Expect `m_axis_last` only on 0x0F, and `o_intr` one cycle after.
- **Backpressure:** toggle `m_axis_ready` randomly at 50% over 3 matrices.
  - Data order and `last` positions must match the single-matrix case.
  - Data/last must stay stable while stalled.
- **Full FIFO:** hold `m_axis_ready`=0 and offer 6 rows.
  - `i_row_ready` drops after 4 accepted rows (FIFO_DEPTH) plus the 1 row held in the register.
  - Release `m_axis_ready`: all rows arrive in order and none is lost.
- **Back-to-back rows:** keep the FIFO fed continuously.
  - No idle cycle between beat 3 of one row and beat 0 of the next.
  - `o_intr` occurs every 16 cycles.
- **Reset mid-matrix:** assert `axi_rst` low after beat 7 of a matrix.
  - Outputs must return to their reset values immediately, via the asynchronous reset.
  - A new matrix must start with row counter 0, and `last` must fall on its 16th beat.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic accelerator result path: geometry,
// row/lane types and the serializer state encoding.
package systolic_pkg;

  localparam int DATA_W = 32;
  localparam int LANES  = 4;
  localparam int ROWS   = 4;
  localparam int ROW_W  = DATA_W * LANES;

  typedef logic [ROW_W-1:0]         row_t;
  typedef logic [$clog2(LANES)-1:0] lane_idx_t;
  typedef logic [$clog2(ROWS)-1:0]  row_idx_t;

  typedef enum logic {IDLE, SEND} state_t;

endpackage

// File: rtl/result_row_fifo.sv
// Row FIFO with first-word fall-through read data; a push and a pop in the
// same cycle are both honoured.
module result_row_fifo
  import systolic_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  row_t wr_data,
  input  logic wr_en,
  output logic full,
  input  logic rd_en,
  output row_t rd_data,
  output logic empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  row_t        mem [FIFO_DEPTH];
  logic        do_wr;
  logic        do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mmu_result_tx.sv
// Serializes buffered MMU result rows into 32-bit AXI4-Stream beats, marks
// the last beat of each result matrix and pulses an interrupt after it.
module mmu_result_tx
  import systolic_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              axi_clk,
  input  logic              axi_rst,
  input  row_t              i_row_data,
  input  logic              i_row_valid,
  output logic              i_row_ready,
  output logic [DATA_W-1:0] m_axis_data,
  output logic              m_axis_valid,
  input  logic              m_axis_ready,
  output logic              m_axis_last,
  output logic              o_intr,
  output logic              o_busy
);

  localparam lane_idx_t LAST_BEAT = lane_idx_t'(LANES - 1);
  localparam row_idx_t  LAST_ROW  = row_idx_t'(ROWS - 1);

  function automatic logic is_last(input row_idx_t r, input lane_idx_t b);
    return (r == LAST_ROW) && (b == LAST_BEAT);
  endfunction

  row_t      fifo_rd;
  logic      fifo_full;
  logic      fifo_empty;
  logic      pop;

  state_t    state,   state_nxt;
  row_t      shift,   shift_nxt;
  lane_idx_t beat,    beat_nxt;
  row_idx_t  row_cnt, row_cnt_nxt;
  logic      valid,   valid_nxt;
  logic      last,    last_nxt;
  logic      intr,    intr_nxt;
  logic      hs;

  result_row_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (axi_clk),
    .rst_n   (axi_rst),
    .wr_data (i_row_data),
    .wr_en   (i_row_valid),
    .full    (fifo_full),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .empty   (fifo_empty)
  );

  assign hs = valid && m_axis_ready;

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    beat_nxt    = beat;
    row_cnt_nxt = row_cnt;
    valid_nxt   = valid;
    last_nxt    = last;
    intr_nxt    = 1'b0;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = fifo_rd;
          beat_nxt  = '0;
          valid_nxt = 1'b1;
          last_nxt  = is_last(row_cnt, '0);
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          intr_nxt = last;
          if (beat != LAST_BEAT) begin
            // Lane 0 sits in the low word, so shifting right exposes the next lane.
            beat_nxt  = beat + 1'b1;
            shift_nxt = shift >> DATA_W;
            last_nxt  = is_last(row_cnt, beat + 1'b1);
          end else begin
            row_cnt_nxt = (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
            beat_nxt    = '0;
            if (!fifo_empty) begin
              pop       = 1'b1;
              shift_nxt = fifo_rd;
              last_nxt  = is_last(row_cnt_nxt, '0);
            end else begin
              shift_nxt = '0;
              valid_nxt = 1'b0;
              last_nxt  = 1'b0;
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_rst) begin
    if (!axi_rst) begin
      state   <= IDLE;
      shift   <= '0;
      beat    <= '0;
      row_cnt <= '0;
      valid   <= 1'b0;
      last    <= 1'b0;
      intr    <= 1'b0;
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      beat    <= beat_nxt;
      row_cnt <= row_cnt_nxt;
      valid   <= valid_nxt;
      last    <= last_nxt;
      intr    <= intr_nxt;
    end
  end

  assign i_row_ready  = !fifo_full;
  assign m_axis_data  = shift[DATA_W-1:0];
  assign m_axis_valid = valid;
  assign m_axis_last  = last;
  assign o_intr       = intr;
  assign o_busy       = !fifo_empty || valid;

endmodule

// File: tb/tb_mmu_result_tx.sv
// Directed bench for mmu_result_tx: stream order, last/intr placement,
// backpressure stability, FIFO full hold-off, back-to-back rows and reset.
module tb_mmu_result_tx;
  import systolic_pkg::*;

  localparam int MAT_BEATS = LANES * ROWS;

  logic              axi_clk = 1'b0;
  logic              axi_rst;
  row_t              i_row_data;
  logic              i_row_valid;
  logic              i_row_ready;
  logic [DATA_W-1:0] m_axis_data;
  logic              m_axis_valid;
  logic              m_axis_ready;
  logic              m_axis_last;
  logic              o_intr;
  logic              o_busy;

  int          compared    = 0;
  int          mismatched  = 0;
  row_t        push_q[$];
  logic [31:0] next_val    = 0;
  logic [31:0] exp_val     = 0;
  int          beat_in_mat = 0;
  bit          intr_due    = 1'b0;
  int          beats_seen  = 0;
  int          cyc;

  always #5 axi_clk = ~axi_clk;

  mmu_result_tx #(.FIFO_DEPTH(4)) dut (
    .axi_clk      (axi_clk),
    .axi_rst      (axi_rst),
    .i_row_data   (i_row_data),
    .i_row_valid  (i_row_valid),
    .i_row_ready  (i_row_ready),
    .m_axis_data  (m_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_ready (m_axis_ready),
    .m_axis_last  (m_axis_last),
    .o_intr       (o_intr),
    .o_busy       (o_busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each row holds four consecutive values, lane 0 lowest.
  task automatic add_rows(input int n);
    for (int i = 0; i < n; i++) begin
      push_q.push_back({next_val + 32'd3, next_val + 32'd2, next_val + 32'd1, next_val});
      next_val = next_val + 32'd4;
    end
  endtask

  // One clock: offer the head row, check outputs against the model, advance.
  task automatic tick(input bit rdy);
    bit hs;
    bit acc;
    bit last_exp;
    i_row_valid  = (push_q.size() != 0);
    i_row_data   = (push_q.size() != 0) ? push_q[0] : '0;
    m_axis_ready = rdy;
    last_exp     = (beat_in_mat == MAT_BEATS - 1);
    chk("intr", o_intr, intr_due);
    if (m_axis_valid) begin
      chk("data", m_axis_data, exp_val);
      chk("last", m_axis_last, last_exp);
    end
    hs  = m_axis_valid && rdy;
    acc = i_row_valid && i_row_ready;
    @(posedge axi_clk);
    #1;
    if (acc) void'(push_q.pop_front());
    if (hs) begin
      exp_val     = exp_val + 32'd1;
      beat_in_mat = (beat_in_mat + 1) % MAT_BEATS;
      beats_seen++;
    end
    intr_due = hs && last_exp;
  endtask

  task automatic drain(input int target, input int budget, input bit bp, output int cycles);
    cycles = 0;
    while (beats_seen < target && cycles < budget) begin
      tick(bp ? 1'($urandom_range(0, 1)) : 1'b1);
      cycles++;
    end
    chk("drain_done", beats_seen >= target, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    axi_rst      = 1'b1;
    i_row_valid  = 1'b0;
    i_row_data   = '0;
    m_axis_ready = 1'b0;
    #1 axi_rst = 1'b0;
    @(posedge axi_clk);
    @(posedge axi_clk);
    #1;
    chk("rst_valid", m_axis_valid, 1'b0);
    chk("rst_last",  m_axis_last,  1'b0);
    chk("rst_intr",  o_intr,       1'b0);
    chk("rst_busy",  o_busy,       1'b0);
    chk("rst_data",  m_axis_data,  '0);
    axi_rst = 1'b1;
    #1;
    chk("rst_ready", i_row_ready, 1'b1);

    // Single matrix: first beat two cycles after the row write.
    add_rows(1);
    tick(1'b1);
    chk("lat_n1_valid", m_axis_valid, 1'b0);
    tick(1'b1);
    chk("lat_n2_valid", m_axis_valid, 1'b1);
    chk("lat_n2_data",  m_axis_data,  32'h0);
    add_rows(3);
    drain(beats_seen + 16, 100, 1'b0, cyc);
    chk("mat1_cycles", cyc, 16);
    tick(1'b1);
    tick(1'b1);
    chk("mat1_idle_busy", o_busy, 1'b0);

    // Three matrices under random backpressure.
    add_rows(12);
    drain(beats_seen + 48, 2000, 1'b1, cyc);
    tick(1'b1);

    // Full FIFO: one row in the register plus four buffered, sixth held off.
    add_rows(6);
    repeat (8) tick(1'b0);
    chk("full_pending", push_q.size(), 1);
    chk("full_ready",   i_row_ready,   1'b0);
    chk("full_busy",    o_busy,        1'b1);
    chk("full_hold_v",  m_axis_valid,  1'b1);
    drain(beats_seen + 24, 200, 1'b0, cyc);
    tick(1'b1);

    // Back-to-back rows: valid must never drop for 40 beats.
    add_rows(10);
    tick(1'b1);
    tick(1'b1);
    for (int i = 0; i < 40; i++) begin
      chk("b2b_valid", m_axis_valid, 1'b1);
      tick(1'b1);
    end
    tick(1'b1);
    chk("b2b_done_busy", o_busy, 1'b0);

    // Reset after beat 7 of a matrix.
    chk("pre_reset_align", beat_in_mat, 0);
    add_rows(4);
    drain(beats_seen + 8, 100, 1'b0, cyc);
    chk("mid_valid", m_axis_valid, 1'b1);
    axi_rst     = 1'b0;
    i_row_valid = 1'b0;
    #1;
    chk("arst_valid", m_axis_valid, 1'b0);
    chk("arst_last",  m_axis_last,  1'b0);
    chk("arst_data",  m_axis_data,  '0);
    chk("arst_intr",  o_intr,       1'b0);
    chk("arst_busy",  o_busy,       1'b0);
    @(posedge axi_clk);
    @(posedge axi_clk);
    #1;
    axi_rst = 1'b1;
    #1;
    chk("post_rst_ready", i_row_ready, 1'b1);
    push_q.delete();
    exp_val     = next_val;
    beat_in_mat = 0;
    intr_due    = 1'b0;
    add_rows(4);
    drain(beats_seen + 16, 100, 1'b0, cyc);
    tick(1'b1);
    tick(1'b1);
    chk("final_busy", o_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
